// File: rtl/sync_fifo_ext_ctrl.sv
// ---------------------------------------------------------------------------
// sync_fifo_ext_ctrl
//
// Single-clock FIFO controller with register-array storage. It sits between
// a producer and a consumer in the same clock domain. Features:
//   - standard registered read or first-word fall-through (FWFT_MODE)
//   - programmable almost-full / almost-empty thresholds
//   - sticky overflow / underflow flags with software clear
//
// Parameters:
//   FIFO_DATA_WIDTH  word width in bits
//   FIFO_ADDR_WIDTH  address width, DEPTH = 2**FIFO_ADDR_WIDTH
//   FWFT_MODE        0 = standard registered read, 1 = first-word fall-through
//   AFULL_TH         fifo_afull when count >= AFULL_TH (1..DEPTH)
//   AEMPTY_TH        fifo_aempty when count <= AEMPTY_TH (0..DEPTH-1)
//
// Ports:
//   clk            FIFO clock, rising edge
//   rst            synchronous active-high reset
//   fifo_wr_en     write request
//   fifo_wr_data   write data
//   fifo_rd_en     read request (pop/acknowledge in FWFT mode)
//   fifo_rd_data   read data
//   fifo_rd_valid  standard: freshly read word; FWFT: FIFO not empty
//   fifo_full      count == DEPTH
//   fifo_empty     count == 0
//   fifo_afull     count >= AFULL_TH
//   fifo_aempty    count <= AEMPTY_TH
//   fifo_data_cnt  stored word count, 0..DEPTH
//   fifo_wr_err    write requested while full (combinational)
//   fifo_rd_err    read requested while empty (combinational)
//   fifo_ovf       sticky: a write was rejected
//   fifo_udf       sticky: a read was rejected
//   fifo_err_clr   clears fifo_ovf / fifo_udf (a new error wins)
// ---------------------------------------------------------------------------
module sync_fifo_ext_ctrl #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int FIFO_ADDR_WIDTH = 8,
  parameter int FWFT_MODE       = 0,
  parameter int AFULL_TH        = (2 ** FIFO_ADDR_WIDTH) - 4,
  parameter int AEMPTY_TH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                       fifo_rd_en,
  output logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
  output logic                       fifo_rd_valid,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       fifo_afull,
  output logic                       fifo_aempty,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_data_cnt,
  output logic                       fifo_wr_err,
  output logic                       fifo_rd_err,
  output logic                       fifo_ovf,
  output logic                       fifo_udf,
  input  logic                       fifo_err_clr
);

  localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;

  // Thresholds resized to the count width so comparisons stay width-exact.
  localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_C  = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
  localparam logic [FIFO_ADDR_WIDTH:0] AFULL_C  = AFULL_TH[FIFO_ADDR_WIDTH:0];
  localparam logic [FIFO_ADDR_WIDTH:0] AEMPTY_C = AEMPTY_TH[FIFO_ADDR_WIDTH:0];

  logic [FIFO_DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_addr;
  logic [FIFO_ADDR_WIDTH-1:0] rd_addr;
  logic [FIFO_ADDR_WIDTH:0]   count;
  logic                       wr_acc;
  logic                       rd_acc;

  // Status decodes come only from the registered count. There is no
  // bypass, so a full FIFO rejects a write even if a read pops the same
  // cycle, and an empty FIFO rejects a read even if a write arrives.
  assign fifo_full     = (count == DEPTH_C);
  assign fifo_empty    = (count == '0);
  assign fifo_afull    = (count >= AFULL_C);
  assign fifo_aempty   = (count <= AEMPTY_C);
  assign fifo_data_cnt = count;

  assign wr_acc      = fifo_wr_en & ~fifo_full;
  assign rd_acc      = fifo_rd_en & ~fifo_empty;
  assign fifo_wr_err = fifo_wr_en & fifo_full;
  assign fifo_rd_err = fifo_rd_en & fifo_empty;

  // Storage array. Contents are deliberately not reset; the pointers and
  // count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_addr] <= fifo_wr_data;
    end
  end

  // Pointers wrap from DEPTH-1 to 0 through natural overflow, and the
  // count moves only when exactly one side is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= '0;
      rd_addr <= '0;
      count   <= '0;
    end else begin
      if (wr_acc) begin
        wr_addr <= wr_addr + 1'b1;
      end
      if (rd_acc) begin
        rd_addr <= rd_addr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags. A new rejection in the same cycle as a clear
  // keeps the flag set so no error event is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_ovf <= 1'b0;
      fifo_udf <= 1'b0;
    end else begin
      if (fifo_wr_err) begin
        fifo_ovf <= 1'b1;
      end else if (fifo_err_clr) begin
        fifo_ovf <= 1'b0;
      end
      if (fifo_rd_err) begin
        fifo_udf <= 1'b1;
      end else if (fifo_err_clr) begin
        fifo_udf <= 1'b0;
      end
    end
  end

  generate
    if (FWFT_MODE != 0) begin : g_fwft
      // The head word is always on the output; a read pops it and the next
      // word shows up after the same edge.
      assign fifo_rd_data  = mem[rd_addr];
      assign fifo_rd_valid = ~fifo_empty;
    end else begin : g_std
      logic [FIFO_DATA_WIDTH-1:0] rd_data_q;
      logic                       rd_valid_q;

      // Registered read: data appears the cycle after an accepted read
      // with a one-cycle valid pulse, and holds otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (rd_acc) begin
          rd_data_q  <= mem[rd_addr];
          rd_valid_q <= 1'b1;
        end else begin
          rd_valid_q <= 1'b0;
        end
      end

      assign fifo_rd_data  = rd_data_q;
      assign fifo_rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ext_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_ext_ctrl
//
// Drives one standard-mode and one FWFT-mode instance (DEPTH=4, AFULL_TH=3,
// AEMPTY_TH=1) with the same directed stimulus. Counts and flags are checked
// against hand-computed values; read data from the standard instance is
// checked by a scoreboard monitor, FWFT head data against the stored-word
// queue.
// ---------------------------------------------------------------------------
module tb_sync_fifo_ext_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AFT   = 3;
  localparam int AET   = 1;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          wr_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en   = 1'b0;
  logic          err_clr = 1'b0;

  logic [DW-1:0] s_rd_data, f_rd_data;
  logic          s_rd_valid, f_rd_valid;
  logic          s_full, f_full, s_empty, f_empty;
  logic          s_afull, f_afull, s_aempty, f_aempty;
  logic [AW:0]   s_cnt, f_cnt;
  logic          s_wr_err, f_wr_err, s_rd_err, f_rd_err;
  logic          s_ovf, f_ovf, s_udf, f_udf;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  sync_fifo_ext_ctrl #(
    .FIFO_DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW), .FWFT_MODE(0),
    .AFULL_TH(AFT), .AEMPTY_TH(AET)
  ) dut_std (
    .clk(clk), .rst(rst),
    .fifo_wr_en(wr_en), .fifo_wr_data(wr_data), .fifo_rd_en(rd_en),
    .fifo_rd_data(s_rd_data), .fifo_rd_valid(s_rd_valid),
    .fifo_full(s_full), .fifo_empty(s_empty),
    .fifo_afull(s_afull), .fifo_aempty(s_aempty),
    .fifo_data_cnt(s_cnt), .fifo_wr_err(s_wr_err), .fifo_rd_err(s_rd_err),
    .fifo_ovf(s_ovf), .fifo_udf(s_udf), .fifo_err_clr(err_clr)
  );

  sync_fifo_ext_ctrl #(
    .FIFO_DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW), .FWFT_MODE(1),
    .AFULL_TH(AFT), .AEMPTY_TH(AET)
  ) dut_fwft (
    .clk(clk), .rst(rst),
    .fifo_wr_en(wr_en), .fifo_wr_data(wr_data), .fifo_rd_en(rd_en),
    .fifo_rd_data(f_rd_data), .fifo_rd_valid(f_rd_valid),
    .fifo_full(f_full), .fifo_empty(f_empty),
    .fifo_afull(f_afull), .fifo_aempty(f_aempty),
    .fifo_data_cnt(f_cnt), .fifo_wr_err(f_wr_err), .fifo_rd_err(f_rd_err),
    .fifo_ovf(f_ovf), .fifo_udf(f_udf), .fifo_err_clr(err_clr)
  );

  // Single comparison point: every check steps the shared counters.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: whenever the standard instance presents a read
  // word, it must match the oldest expected word queued by the stimulus.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (s_rd_valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL std unexpected rd_valid: got data 0x%0h, expected no read", s_rd_data);
      end else begin
        e = exp_q.pop_front();
        check("std rd_data", 32'(s_rd_data), 32'(e));
      end
    end
  end

  // One clock of stimulus: drive on the falling edge, check the
  // combinational error outputs, queue expected read data, then step
  // past the rising edge.
  task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic r,
                               input logic c, input logic exp_werr, input logic exp_rerr);
    logic wacc, racc;
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    err_clr = c;
    #1;
    check("std wr_err", 32'(s_wr_err), 32'(exp_werr));
    check("std rd_err", 32'(s_rd_err), 32'(exp_rerr));
    check("fwft wr_err", 32'(f_wr_err), 32'(exp_werr));
    check("fwft rd_err", 32'(f_rd_err), 32'(exp_rerr));
    racc = r && (model_q.size() > 0);
    wacc = w && (model_q.size() < DEPTH);
    if (racc) exp_q.push_back(model_q.pop_front());
    if (wacc) model_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Status checks against a hand-computed count and sticky flag state.
  task automatic checkOutput(input int cnt, input logic ovf, input logic udf);
    check("std cnt", 32'(s_cnt), 32'(cnt));
    check("std full", 32'(s_full), 32'(cnt == DEPTH));
    check("std empty", 32'(s_empty), 32'(cnt == 0));
    check("std afull", 32'(s_afull), 32'(cnt >= AFT));
    check("std aempty", 32'(s_aempty), 32'(cnt <= AET));
    check("std ovf", 32'(s_ovf), 32'(ovf));
    check("std udf", 32'(s_udf), 32'(udf));
    check("fwft cnt", 32'(f_cnt), 32'(cnt));
    check("fwft empty", 32'(f_empty), 32'(cnt == 0));
    check("fwft rd_valid", 32'(f_rd_valid), 32'(cnt != 0));
    check("fwft ovf", 32'(f_ovf), 32'(ovf));
    check("fwft udf", 32'(f_udf), 32'(udf));
    if (model_q.size() > 0) begin
      check("fwft rd_data", 32'(f_rd_data), 32'(model_q[0]));
    end
  endtask

  // Reset with both enables high to show requests during reset are ignored.
  task automatic doReset();
    @(negedge clk);
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hFF;
    rd_en   = 1'b1;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_q.delete();
    exp_q.delete();
    #1;
  endtask

  initial begin
    doReset();
    checkOutput(0, 1'b0, 1'b0);
    check("std rd_valid after reset", 32'(s_rd_valid), 32'd0);
    check("std rd_data after reset", 32'(s_rd_data), 32'd0);

    // First cycle after reset is empty: a read is rejected.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput(0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, 1'b0, 1'b0);

    // Fill to full, then overflow.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput(i + 1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput(4, 1'b1, 1'b0);

    // Full with both enables: read wins, write rejected.
    applyStimulus(1'b1, 8'hEF, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput(3, 1'b1, 1'b0);
    // A full FIFO accepts a write the cycle after a read.
    applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(4, 1'b1, 1'b0);

    // Drain, then underflow; standard rd_data holds the last word.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput(3 - i, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput(0, 1'b1, 1'b1);
    check("std rd_data holds", 32'(s_rd_data), 32'hA4);
    check("std rd_valid after rejected read", 32'(s_rd_valid), 32'd0);

    // Empty with both enables: write accepted, read rejected.
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput(1, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(0, 1'b1, 1'b1);

    // FWFT: word appears without a read, pop empties.
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(1, 1'b1, 1'b1);
    check("fwft rd_data 0x55", 32'(f_rd_data), 32'h55);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(0, 1'b1, 1'b1);

    // Clear with no new error.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, 1'b0, 1'b0);

    // Streaming 3*DEPTH words with both enables high, across pointer wrap.
    applyStimulus(1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(2, 1'b0, 1'b0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      applyStimulus(1'b1, 8'hB2 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput(2, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(0, 1'b0, 1'b0);

    // Fill, then clear coincident with a new overflow: set wins.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput(i + 1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'hCC, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput(4, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput(4, 1'b0, 1'b0);

    // Reset mid-operation discards the stored words.
    doReset();
    checkOutput(0, 1'b0, 1'b0);
    check("std rd_valid after mid reset", 32'(s_rd_valid), 32'd0);
    applyStimulus(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput(0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(0, 1'b0, 1'b0);

    // Every queued read must have been presented by the DUT.
    check("pending expected reads", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
